// File: rtl/alt_mge_core_pll_rst_ctrl.sv
// Power-up / reset sequencer for the MGE core fPLL.
// Drives pll_powerdown, watches the PLL's asynchronous lock and calibration
// status, and qualifies pll_ready and core_reset. Loss of lock or
// recalibration while ready re-runs the sequence. Timeouts force a retry.
// Runs on the free-running management clock.
module alt_mge_core_pll_rst_ctrl #(
  parameter int PD_CYCLES    = 100,
  parameter int CAL_TIMEOUT  = 1048576,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int LOCK_STABLE  = 1000,
  parameter int LOL_FILTER   = 4,
  parameter int RELEASE_DLY  = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_rst_req,
  input  logic       pll_locked,
  input  logic       pll_cal_busy,
  output logic       pll_powerdown,
  output logic       pll_ready,
  output logic       core_reset,
  output logic [2:0] state,
  output logic [7:0] lol_count,
  output logic       timeout_err
);

  localparam logic [2:0] PWRDN     = 3'd0;
  localparam logic [2:0] WAIT_CAL  = 3'd1;
  localparam logic [2:0] WAIT_LOCK = 3'd2;
  localparam logic [2:0] STABLE    = 3'd3;
  localparam logic [2:0] READY     = 3'd4;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared counter serves every state, so it is sized for the largest limit.
  localparam int MAXP = max_of(max_of(max_of(PD_CYCLES, CAL_TIMEOUT),
                                      max_of(LOCK_TIMEOUT, LOCK_STABLE)),
                               RELEASE_DLY);
  localparam int CW = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam int LW = (LOL_FILTER > 1) ? $clog2(LOL_FILTER) : 1;

  localparam logic [CW-1:0] PD_LAST     = CW'(PD_CYCLES - 1);
  localparam logic [CW-1:0] CAL_LAST    = CW'(CAL_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] REL_LAST    = CW'(RELEASE_DLY - 1);
  localparam logic [LW-1:0] LOL_LAST    = LW'(LOL_FILTER - 1);

  logic [1:0]             rst_pipe;
  logic                   rst_hold;
  logic [SYNC_STAGES-1:0] locked_sync;
  logic [SYNC_STAGES-1:0] cal_sync;
  logic                   locked_s;
  logic                   cal_busy_s;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [LW-1:0] lol_filt;
  logic [LW-1:0] lol_filt_n;
  logic [2:0]    state_n;
  logic          timeout_set;
  logic          lol_event;
  logic          core_reset_n;

  // Reset asserts immediately but its release reaches the FSM two clocks later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_pipe <= 2'b11;
    else       rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_hold = rst_pipe[1];

  // Bring the asynchronous PLL status into the management clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_sync <= '0;
      cal_sync    <= '0;
    end else begin
      locked_sync <= {locked_sync[SYNC_STAGES-2:0], pll_locked};
      cal_sync    <= {cal_sync[SYNC_STAGES-2:0], pll_cal_busy};
    end
  end

  assign locked_s   = locked_sync[SYNC_STAGES-1];
  assign cal_busy_s = cal_sync[SYNC_STAGES-1];

  // Next-state logic: request beats recal, recal beats lock loss, and lock
  // loss beats counter expiry. Any state change clears the counters.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lol_filt_n  = '0;
    timeout_set = 1'b0;
    lol_event   = 1'b0;
    if (pll_rst_req) begin
      state_n = PWRDN;
      cnt_n   = '0;
    end else begin
      case (state)
        PWRDN: begin
          if (cnt == PD_LAST) begin
            state_n = WAIT_CAL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        WAIT_CAL: begin
          if (!cal_busy_s) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == CAL_LAST) begin
            state_n     = PWRDN;
            cnt_n       = '0;
            timeout_set = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state_n = STABLE;
            cnt_n   = '0;
          end else if (cnt == LOCK_LAST) begin
            state_n     = PWRDN;
            cnt_n       = '0;
            timeout_set = 1'b1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        STABLE: begin
          if (cal_busy_s) begin
            state_n = WAIT_CAL;
            cnt_n   = '0;
          end else if (!locked_s) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_n = READY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        READY: begin
          if (cal_busy_s) begin
            state_n   = WAIT_CAL;
            cnt_n     = '0;
            lol_event = 1'b1;
          end else if (!locked_s && (lol_filt == LOL_LAST)) begin
            state_n   = WAIT_LOCK;
            cnt_n     = '0;
            lol_event = 1'b1;
          end else begin
            lol_filt_n = locked_s ? '0 : lol_filt + LW'(1);
            if (cnt != REL_LAST) cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = PWRDN;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // core_reset releases only once READY has lasted RELEASE_DLY cycles.
  always_comb begin
    core_reset_n = 1'b1;
    if ((state == READY) && (state_n == READY) && (cnt == REL_LAST))
      core_reset_n = 1'b0;
  end

  // State, counters and outputs, all registered from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= PWRDN;
      cnt           <= '0;
      lol_filt      <= '0;
      pll_powerdown <= 1'b1;
      pll_ready     <= 1'b0;
      core_reset    <= 1'b1;
      lol_count     <= '0;
      timeout_err   <= 1'b0;
    end else if (rst_hold) begin
      state         <= PWRDN;
      cnt           <= '0;
      lol_filt      <= '0;
      pll_powerdown <= 1'b1;
      pll_ready     <= 1'b0;
      core_reset    <= 1'b1;
      lol_count     <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      lol_filt      <= lol_filt_n;
      pll_powerdown <= (state_n == PWRDN);
      pll_ready     <= (state_n == READY);
      core_reset    <= core_reset_n;
      if (timeout_set) timeout_err <= 1'b1;
      if (lol_event && (lol_count != 8'hFF)) lol_count <= lol_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alt_mge_core_pll_rst_ctrl.sv
// Directed bench for the MGE core PLL reset sequencer.
// Timeouts are shortened so every scenario fits in a short run; the other
// timing parameters keep their default values.
module tb_alt_mge_core_pll_rst_ctrl;

  localparam int PD     = 100;
  localparam int CAL_TO = 256;
  localparam int LOCK_TO = 512;
  localparam int STAB   = 1000;
  localparam int LOLF   = 4;
  localparam int REL    = 16;
  localparam int SYNC   = 2;

  localparam logic [2:0] S_PWRDN     = 3'd0;
  localparam logic [2:0] S_WAIT_CAL  = 3'd1;
  localparam logic [2:0] S_WAIT_LOCK = 3'd2;
  localparam logic [2:0] S_STABLE    = 3'd3;
  localparam logic [2:0] S_READY     = 3'd4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_rst_req;
  logic       pll_locked;
  logic       pll_cal_busy;
  logic       pll_powerdown;
  logic       pll_ready;
  logic       core_reset;
  logic [2:0] state;
  logic [7:0] lol_count;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  alt_mge_core_pll_rst_ctrl #(
    .PD_CYCLES(PD), .CAL_TIMEOUT(CAL_TO), .LOCK_TIMEOUT(LOCK_TO),
    .LOCK_STABLE(STAB), .LOL_FILTER(LOLF), .RELEASE_DLY(REL), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .pll_rst_req(pll_rst_req), .pll_locked(pll_locked),
    .pll_cal_busy(pll_cal_busy), .pll_powerdown(pll_powerdown), .pll_ready(pll_ready),
    .core_reset(core_reset), .state(state), .lol_count(lol_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Bounded wait for a given state; n is the number of rising edges taken, -1 if never reached.
  task automatic wait_state(input logic [2:0] target, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (state === target) begin
        n = i;
        break;
      end
    end
  endtask

  // Bounded count of rising edges until pll_ready rises; -1 if it never does.
  task automatic edges_to_ready(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (pll_ready === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; pll_rst_req = 1'b0; pll_locked = 1'b0; pll_cal_busy = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (state !== S_PWRDN) begin errors++; $display("[TB] FAIL rst_state: got %0d expected %0d", state, S_PWRDN); end
    checks++; if (pll_powerdown !== 1'b1 || pll_ready !== 1'b0 || core_reset !== 1'b1) begin errors++; $display("[TB] FAIL rst_outputs: got pd=%b rdy=%b crst=%b expected pd=1 rdy=0 crst=1", pll_powerdown, pll_ready, core_reset); end
    checks++; if (lol_count !== 8'd0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_status: got lol=%0d to=%b expected lol=0 to=0", lol_count, timeout_err); end
    @(negedge clk); reset = 1'b0;
    // Two clocks of reset-release synchronisation precede the PD_CYCLES count.
    n = -1;
    for (int i = 1; i <= PD + 20; i++) begin
      @(posedge clk); #1;
      if (pll_powerdown === 1'b0) begin n = i; break; end
    end
    checks++; if (n != PD + 2) begin errors++; $display("[TB] FAIL rst_pd_width: got %0d expected %0d", n, PD + 2); end
  endtask

  task automatic test_bringup();
    int n;
    checks++; if (state !== S_WAIT_CAL) begin errors++; $display("[TB] FAIL bu_waitcal: got %0d expected %0d", state, S_WAIT_CAL); end
    repeat (49) @(posedge clk);
    @(negedge clk); pll_cal_busy = 1'b0;
    wait_state(S_WAIT_LOCK, 10, n);
    checks++; if (n != SYNC + 1) begin errors++; $display("[TB] FAIL bu_cal_latency: got %0d expected %0d", n, SYNC + 1); end
    repeat (147) @(posedge clk);
    #1;
    checks++; if (state !== S_WAIT_LOCK) begin errors++; $display("[TB] FAIL bu_waitlock: got %0d expected %0d", state, S_WAIT_LOCK); end
    @(negedge clk); pll_locked = 1'b1;
    @(posedge clk);
    edges_to_ready(STAB + 20, n);
    checks++; if (n != STAB + SYNC) begin errors++; $display("[TB] FAIL bu_ready_latency: got %0d expected %0d", n, STAB + SYNC); end
    checks++; if (state !== S_READY || core_reset !== 1'b1) begin errors++; $display("[TB] FAIL bu_ready_entry: got st=%0d crst=%b expected st=4 crst=1", state, core_reset); end
    n = -1;
    for (int i = 1; i <= REL + 10; i++) begin
      @(posedge clk); #1;
      if (core_reset === 1'b0) begin n = i; break; end
    end
    checks++; if (n != REL) begin errors++; $display("[TB] FAIL bu_release_dly: got %0d expected %0d", n, REL); end
    checks++; if (pll_ready !== 1'b1 || lol_count !== 8'd0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL bu_final: got rdy=%b lol=%0d to=%b expected rdy=1 lol=0 to=0", pll_ready, lol_count, timeout_err); end
  endtask

  task automatic test_glitch_filter();
    int n;
    logic ok;
    @(negedge clk); pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); pll_locked = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (pll_ready !== 1'b1 || state !== S_READY || core_reset !== 1'b0) ok = 1'b0;
    end
    checks++; if (!ok || lol_count !== 8'd0) begin errors++; $display("[TB] FAIL glitch3_ignored: got ok=%b lol=%0d expected ok=1 lol=0", ok, lol_count); end
    @(negedge clk); pll_locked = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); pll_locked = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== S_READY) begin errors++; $display("[TB] FAIL glitch4_early: got %0d expected %0d", state, S_READY); end
    @(posedge clk); #1;
    checks++; if (state !== S_WAIT_LOCK) begin errors++; $display("[TB] FAIL glitch4_state: got %0d expected %0d", state, S_WAIT_LOCK); end
    checks++; if (pll_ready !== 1'b0 || core_reset !== 1'b1 || lol_count !== 8'd1) begin errors++; $display("[TB] FAIL glitch4_outputs: got rdy=%b crst=%b lol=%0d expected rdy=0 crst=1 lol=1", pll_ready, core_reset, lol_count); end
    wait_state(S_READY, STAB + 20, n);
    checks++; if (n < 0) begin errors++; $display("[TB] FAIL glitch_relock: got %0d expected ready", n); end
  endtask

  task automatic test_recal_and_request();
    int n;
    @(negedge clk); pll_cal_busy = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (state !== S_READY) begin errors++; $display("[TB] FAIL recal_early: got %0d expected %0d", state, S_READY); end
    @(posedge clk); #1;
    checks++; if (state !== S_WAIT_CAL || pll_ready !== 1'b0 || core_reset !== 1'b1) begin errors++; $display("[TB] FAIL recal_exit: got st=%0d rdy=%b crst=%b expected st=1 rdy=0 crst=1", state, pll_ready, core_reset); end
    checks++; if (lol_count !== 8'd2) begin errors++; $display("[TB] FAIL recal_lol: got %0d expected 2", lol_count); end
    @(negedge clk); pll_cal_busy = 1'b0;
    wait_state(S_READY, STAB + 20, n);
    checks++; if (n < 0) begin errors++; $display("[TB] FAIL recal_reready: got %0d expected ready", n); end
    // Request lands on the same edge the FSM first sees cal_busy.
    @(negedge clk); pll_cal_busy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); pll_rst_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== S_PWRDN || pll_powerdown !== 1'b1 || pll_ready !== 1'b0) begin errors++; $display("[TB] FAIL req_wins: got st=%0d pd=%b rdy=%b expected st=0 pd=1 rdy=0", state, pll_powerdown, pll_ready); end
    checks++; if (lol_count !== 8'd2) begin errors++; $display("[TB] FAIL req_lol: got %0d expected 2", lol_count); end
    @(negedge clk); pll_rst_req = 1'b0;
    n = -1;
    for (int i = 1; i <= PD + 20; i++) begin
      @(posedge clk); #1;
      if (pll_powerdown === 1'b0) begin n = i; break; end
    end
    checks++; if (n != PD) begin errors++; $display("[TB] FAIL req_pd_width: got %0d expected %0d", n, PD); end
    checks++; if (state !== S_WAIT_CAL) begin errors++; $display("[TB] FAIL req_waitcal: got %0d expected %0d", state, S_WAIT_CAL); end
  endtask

  task automatic test_unstable_lock();
    int n;
    @(negedge clk); pll_cal_busy = 1'b0;
    wait_state(S_STABLE, 20, n);
    checks++; if (n != SYNC + 2) begin errors++; $display("[TB] FAIL unst_enter: got %0d expected %0d", n, SYNC + 2); end
    repeat (499) @(posedge clk);
    #1;
    checks++; if (state !== S_STABLE) begin errors++; $display("[TB] FAIL unst_mid: got %0d expected %0d", state, S_STABLE); end
    @(negedge clk); pll_locked = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); pll_locked = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== S_WAIT_LOCK) begin errors++; $display("[TB] FAIL unst_drop: got %0d expected %0d", state, S_WAIT_LOCK); end
    edges_to_ready(STAB + 20, n);
    checks++; if (n != STAB + SYNC) begin errors++; $display("[TB] FAIL unst_restart: got %0d expected %0d", n, STAB + SYNC); end
  endtask

  task automatic test_lock_timeout();
    int n;
    @(negedge clk); pll_locked = 1'b0; pll_rst_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (state !== S_PWRDN || lol_count !== 8'd2) begin errors++; $display("[TB] FAIL to_req: got st=%0d lol=%0d expected st=0 lol=2", state, lol_count); end
    @(negedge clk); pll_rst_req = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_pre: got %b expected 0", timeout_err); end
    wait_state(S_WAIT_LOCK, PD + 20, n);
    checks++; if (n != PD + 1) begin errors++; $display("[TB] FAIL to_enter: got %0d expected %0d", n, PD + 1); end
    n = -1;
    for (int i = 1; i <= LOCK_TO + 20; i++) begin
      @(posedge clk); #1;
      if (state !== S_WAIT_LOCK) begin n = i; break; end
    end
    checks++; if (n != LOCK_TO) begin errors++; $display("[TB] FAIL to_duration: got %0d expected %0d", n, LOCK_TO); end
    checks++; if (state !== S_PWRDN || timeout_err !== 1'b1 || pll_powerdown !== 1'b1) begin errors++; $display("[TB] FAIL to_outputs: got st=%0d to=%b pd=%b expected st=0 to=1 pd=1", state, timeout_err, pll_powerdown); end
    wait_state(S_WAIT_CAL, PD + 10, n);
    checks++; if (n != PD) begin errors++; $display("[TB] FAIL to_retry_cal: got %0d expected %0d", n, PD); end
    wait_state(S_WAIT_LOCK, 10, n);
    checks++; if (n != 1) begin errors++; $display("[TB] FAIL to_retry_lock: got %0d expected 1", n); end
  endtask

  task automatic test_async_reset();
    checks++; if (lol_count !== 8'd2 || timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre: got lol=%0d to=%b expected lol=2 to=1", lol_count, timeout_err); end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    checks++; if (state !== S_PWRDN || pll_powerdown !== 1'b1 || pll_ready !== 1'b0 || core_reset !== 1'b1) begin errors++; $display("[TB] FAIL ar_outputs: got st=%0d pd=%b rdy=%b crst=%b expected st=0 pd=1 rdy=0 crst=1", state, pll_powerdown, pll_ready, core_reset); end
    checks++; if (lol_count !== 8'd0 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL ar_status: got lol=%0d to=%b expected lol=0 to=0", lol_count, timeout_err); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  // Scenario sequence; each task leaves the DUT where the next one expects it.
  initial begin
    test_reset();
    test_bringup();
    test_glitch_filter();
    test_recal_and_request();
    test_unstable_lock();
    test_lock_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung scenario.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
